// File: rtl/apb_cmd_queue.sv
// Command/response queue in front of an APB controller FSM: commands wait in a FIFO,
// the head entry drives the APB request, and each completion pushes a response.
module apb_cmd_queue #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              req,
    input  logic              done,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    input  logic [31:0]       prdata,
    input  logic              pslverr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_write,
    output logic              busy
);
    localparam int CPW  = $clog2(CMD_DEPTH);
    localparam int CW   = CPW + 1;
    localparam int CW1  = CW + 1;
    localparam int RPW  = $clog2(RSP_DEPTH);
    localparam int RW   = RPW + 1;
    localparam int RW1  = RW + 1;
    localparam int CE_W = ADDR_W + 1 + 32 + 4;
    localparam int RE_W = 32 + 1 + 1;

    logic [CE_W-1:0] cmd_mem [CMD_DEPTH];
    logic [RE_W-1:0] rsp_mem [RSP_DEPTH];

    logic [CPW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CW-1:0]  cmd_count_q, cmd_count_d;
    logic [RPW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [RW-1:0]  rsp_count_q, rsp_count_d;

    logic           cmd_push, done_eff, rsp_pop;
    logic [CW1-1:0] cmd_left;
    logic [RW1-1:0] rsp_next;
    logic [3:0]     head_strb;

    assign cmd_ready = reset_n && (cmd_count_q < CW'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_count_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign busy      = (cmd_count_q != '0);

    // A completion with nothing queued, or with no room for its response, is dropped
    // so the counts can never run past their limits.
    assign done_eff = done && busy && ((rsp_count_q < RW'(RSP_DEPTH)) || rsp_pop);

    // Looks one cycle ahead so a completing transfer chains straight into the next one.
    assign cmd_left = {1'b0, cmd_count_q} - CW1'(done_eff);
    assign rsp_next = {1'b0, rsp_count_q} + RW1'(done_eff) - RW1'(rsp_pop);
    assign req      = (cmd_left != '0) && (rsp_next < RW1'(RSP_DEPTH));

    assign {paddr, pwrite, pwdata, head_strb} = cmd_mem[cmd_rd_ptr_q];
    assign pstrb = pwrite ? head_strb : 4'h0;
    assign {rsp_rdata, rsp_err, rsp_write} = rsp_mem[rsp_rd_ptr_q];

    always_comb begin
        cmd_wr_ptr_d = cmd_wr_ptr_q + CPW'(cmd_push);
        cmd_rd_ptr_d = cmd_rd_ptr_q + CPW'(done_eff);
        cmd_count_d  = cmd_count_q + CW'(cmd_push) - CW'(done_eff);
        rsp_wr_ptr_d = rsp_wr_ptr_q + RPW'(done_eff);
        rsp_rd_ptr_d = rsp_rd_ptr_q + RPW'(rsp_pop);
        rsp_count_d  = rsp_count_q + RW'(done_eff) - RW'(rsp_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
        end else begin
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_count_q  <= cmd_count_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_count_q  <= rsp_count_d;
        end
    end

    // Storage is left unreset; it is only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wr_ptr_q] <= {cmd_addr, cmd_write, cmd_wdata, cmd_strb};
        if (done_eff)
            rsp_mem[rsp_wr_ptr_q] <= {(pwrite ? 32'h0 : prdata), pslverr, pwrite};
    end
endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RSP_DEPTH, 2, response FIFO entries (power of 2, >=2)
- ADDR_W, 32, address width
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_W  transfer address
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
- req  out  1  transfer request to the APB controller FSM
- done  in  1  one-cycle completion pulse from the controller (DATA state and p_ready)
- paddr  out  ADDR_W  head-entry address
- pwrite  out  1  head-entry direction
- pwdata  out  32  head-entry write data
- pstrb  out  4  head-entry strobes (forced 0 for reads)
- prdata  in  32  APB read data, valid when done=1
- pslverr  in  1  APB error, valid when done=1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  captured pslverr
- rsp_write  out  1  response belongs to a write
- busy  out  1  command FIFO non-empty

Function
REQ-003 Command FIFO SHALL push on cmd_valid&&cmd_ready and pop on done; push and pop in the same cycle SHALL leave the count unchanged.
REQ-004 cmd_ready SHALL be 1 iff cmd_count<CMD_DEPTH; it SHALL NOT depend combinationally on done (no full-bypass).
REQ-005 paddr/pwrite/pwdata/pstrb SHALL be driven from the head entry and SHALL stay constant from req assertion until the cycle done is high.
REQ-006 req SHALL be combinational: (cmd_count - done) > 0 AND (rsp_count + done - rsp_pop) < RSP_DEPTH, where rsp_pop = rsp_valid&&rsp_ready.
REQ-007 In the done cycle, req SHALL reflect the next entry so the controller chains back-to-back transfers (DATA->ADDRESS) with zero idle cycles.
REQ-008 Between done pulses, req SHALL be monotonic (never deasserts once asserted).
REQ-009 On done, the response FIFO SHALL push {rdata = pwrite ? 0 : prdata, err = pslverr, write = pwrite}.
REQ-010 done while cmd_count==0 SHALL be ignored: no pop, no response push, counters unchanged.
REQ-011 Response FIFO: rsp_valid = rsp_count>0; outputs from the head entry; simultaneous push and pop allowed at any fill level, including full-with-pop.
REQ-012 Pointers SHALL wrap modulo depth; counts SHALL be log2(depth)+1 bits wide and never exceed depth.
REQ-013 Responses SHALL return in command order; errors SHALL NOT stall or flush the queue.
REQ-014 busy SHALL equal cmd_count>0.

Reset
REQ-015 reset_n low SHALL asynchronously clear both FIFOs' pointers and counts; req=0, rsp_valid=0, busy=0, and cmd_ready=0 while reset_n is low.
REQ-016 FIFO data storage need not be reset; paddr/pwdata are don't-care while busy=0.
REQ-017 Reset mid-transfer SHALL discard all queued commands and responses; the first cycle after release SHALL show cmd_ready=1 and req=0.

Verification
REQ-018 Single read: push addr 0x10, read; hold done low 3 cycles, then pulse done with prdata=0xCAFE0001 -> req=1 throughout, paddr=0x10; next cycle rsp_valid=1, rsp_rdata=0xCAFE0001, rsp_err=0, busy=0.
REQ-019 Back-to-back: push 3 writes (0x0, 0x4, 0x8) -> req stays high across every done; paddr advances 0x0->0x4->0x8 on the cycle after each done; 3 in-order responses with rsp_write=1, rsp_rdata=0.
REQ-020 Full: push 4 commands with done=0 -> cmd_ready=0 after the 4th; a done pulse -> cmd_ready=1 next cycle, not in the done cycle.
REQ-021 Response backpressure: rsp_ready=0, 3 reads queued -> after 2 dones req=0 and busy=1; one rsp_ready pulse -> req=1 in that same cycle.
REQ-022 Error: read with pslverr=1 at done -> rsp_err=1; the following command still issues normally.
REQ-023 Reset: assert reset_n low while in DATA with 2 queued commands -> req=0, rsp_valid=0 immediately; after release cmd_ready=1, busy=0.
